mdu_ex: RTL
===========

# mdu_ex

Multiply/divide unit for the EX stage of the pipelined MIPS core. It accepts mult/div/move-to-HI/LO operations from EX, models multi-cycle latency with a busy counter, and holds the architectural HI/LO registers. It also drives the `MDM_RD` read value (mfhi/mflo) that the EX→MEM pipeline register captures.

## Interface
Parameters:
- `MUL_CYCLES`, default 5: busy cycles for the mult family.
- `DIV_CYCLES`, default 10: busy cycles for the div family.

Ports:
- `clk`, in, 1: single clock. Rising edge.
- `reset`, in, 1: asynchronous, active-high.
- `start`, in, 1: qualifies `MDOp` as an issuing write-type operation this cycle.
- `MDOp`, in, 4: operation code (`mdu_pkg`).
- `A`, in, 32: forwarded rs value.
- `B`, in, 32: forwarded rt value.
- `busy`, out, 1: a multi-cycle operation is in flight.
- `HI`, out, 32: architectural HI register.
- `LO`, out, 32: architectural LO register.
- `MDM_RD`, out, 32: HI when `MDOp`=MFHI, LO when `MDOp`=MFLO, else 0. Combinational.

## Operation
- Op codes:
  - NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4
  - MFHI=5, MFLO=6, MTHI=7, MTLO=8
  - MADD=9, MADDU=10, MSUB=11, MSUBU=12
- FSM states: IDLE and BUSY.
- IDLE with `start`=1 and a mult or div op:
  - Latch `A`, `B` and the op.
  - Load the counter with `MUL_CYCLES` or `DIV_CYCLES`.
  - Go to BUSY.
- BUSY:
  - Counter decrements each cycle.
  - On the edge where the counter equals 1: write HI/LO from the latched operands and return to IDLE.
- MTHI/MTLO with `start`=1 in IDLE: write `A` to HI/LO on the next edge. `busy` stays 0.
- `start` while BUSY: ignored; no state change. The hazard unit stalls on `busy | start`, so this is a bench assertion, not a functional path.
- MFHI/MFLO need no `start`. `MDM_RD` reflects the current register contents, including the pre-update values while BUSY.
- Arithmetic:
  - MULT/MULTU: `{HI,LO}` = 64-bit signed/unsigned product.
  - DIV/DIVU: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF (signed): LO=0x80000000, HI=0.
  - Divide by zero: HI and LO unchanged, but the full `DIV_CYCLES` busy period still runs.
- Reset values: `busy`=0, `HI`=0, `LO`=0, state IDLE, counter 0, latched operands 0.
- Reset mid-operation: everything clears immediately. The in-flight result is discarded and never written.

## Timing
- `start` sampled at edge t.
- `busy` is high from after t through edge t+N, where N = `MUL_CYCLES` or `DIV_CYCLES`, i.e. exactly N cycles.
- HI/LO update at edge t+N. `busy` is low in the same cycle the new values become visible.
- A new `start` is accepted at edge t+N+1 at the earliest, because `busy` is sampled high at t+N.
- MTHI/MTLO: visible one cycle after the `start` edge; zero busy cycles.
- `MDM_RD` has zero latency from `MDOp`/HI/LO.

## Configuration
- Macro: `MDU_MADD_EN`.
- Defined: MADD/MADDU/MSUB/MSUBU are supported. Each computes `{HI,LO}` ± signed/unsigned 64-bit product, using HI/LO as they are at the start edge, with `MUL_CYCLES` latency.
- Undefined: op codes 9–12 with `start` are treated as NONE. No busy, no write.

## Structure
- Package `mdu_pkg` holds:
  - the op-code localparams;
  - the state encodings IDLE/BUSY;
  - the default latencies 5 and 10.
- Sub-module `mdu_arith`: purely combinational. Inputs: latched op, operands, current HI/LO. Output: the 64-bit next `{HI,LO}` and a write-enable, which is 0 for divide-by-zero.
- The top level holds the FSM, counter, operand latches and HI/LO registers.

## Test plan
- MULT A=0xFFFFFFFF, B=2 → `busy` high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE. MULTU with the same operands → HI=0x00000001, LO=0xFFFFFFFE.
- DIV A=0xFFFFFFF9 (−7), B=2 → `busy` high 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU with B=0 after HI=0x11, LO=0x22 → `busy` high 10 cycles, then HI=0x11, LO=0x22 unchanged.
- MTHI A=0x12345678, then MDOp=MFHI next cycle → `MDM_RD`=0x12345678 and `busy` never asserted.
- DIV started, `reset` pulsed in busy cycle 3 → `busy`=0 and HI=LO=0 asynchronously; no write at the original t+10.
- With `MDU_MADD_EN`: HI:LO=0:5, MADD A=3, B=4 → after 5 cycles LO=17, HI=0. Also pulse `start` while BUSY → no effect.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared op codes, FSM states and default latencies for the multiply/divide unit.
// Optional MADD/MADDU/MSUB/MSUBU support is enabled by defining MDU_MADD_EN.
package mdu_pkg;

  localparam int unsigned OP_W  = 4;
  localparam int unsigned CNT_W = 8;

  localparam int unsigned MUL_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF = 10;

  localparam logic [OP_W-1:0] OP_NONE  = 4'd0;
  localparam logic [OP_W-1:0] OP_MULT  = 4'd1;
  localparam logic [OP_W-1:0] OP_MULTU = 4'd2;
  localparam logic [OP_W-1:0] OP_DIV   = 4'd3;
  localparam logic [OP_W-1:0] OP_DIVU  = 4'd4;
  localparam logic [OP_W-1:0] OP_MFHI  = 4'd5;
  localparam logic [OP_W-1:0] OP_MFLO  = 4'd6;
  localparam logic [OP_W-1:0] OP_MTHI  = 4'd7;
  localparam logic [OP_W-1:0] OP_MTLO  = 4'd8;
  localparam logic [OP_W-1:0] OP_MADD  = 4'd9;
  localparam logic [OP_W-1:0] OP_MADDU = 4'd10;
  localparam logic [OP_W-1:0] OP_MSUB  = 4'd11;
  localparam logic [OP_W-1:0] OP_MSUBU = 4'd12;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Ops that occupy the unit for the multiply latency.
  function automatic logic is_mul_op(input logic [OP_W-1:0] op);
    logic r;
    r = (op == OP_MULT) || (op == OP_MULTU);
`ifdef MDU_MADD_EN
    r = r || (op == OP_MADD) || (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
`endif
    return r;
  endfunction

  function automatic logic is_div_op(input logic [OP_W-1:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational datapath: next {HI,LO} and write enable for a latched mult/div op.
// Accumulating ops are compiled in only when MDU_MADD_EN is defined.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [OP_W-1:0] op,
  input  logic [31:0]     a,
  input  logic [31:0]     b,
  input  logic [31:0]     hi,
  input  logic [31:0]     lo,
  output logic [63:0]     hilo_c,
  output logic            we_c
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        div_ovf;
  logic [31:0] b_safe_s;
  logic [31:0] b_safe_u;
  logic [31:0] quo_s;
  logic [31:0] rem_s;
  logic [31:0] quo_u;
  logic [31:0] rem_u;

  assign prod_s = 64'($signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}));
  assign prod_u = {32'd0, a} * {32'd0, b};

  // Divisor of 1 for the most-negative / -1 case yields quotient=a, remainder=0.
  assign div_ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
  assign b_safe_s = ((b == 32'd0) || div_ovf) ? 32'd1 : b;
  assign b_safe_u = (b == 32'd0) ? 32'd1 : b;

  assign quo_s = 32'($signed(a) / $signed(b_safe_s));
  assign rem_s = 32'($signed(a) % $signed(b_safe_s));
  assign quo_u = a / b_safe_u;
  assign rem_u = a % b_safe_u;

  always_comb begin
    hilo_c = {hi, lo};
    we_c   = 1'b0;
    case (op)
      OP_MULT:  begin hilo_c = prod_s;         we_c = 1'b1;          end
      OP_MULTU: begin hilo_c = prod_u;         we_c = 1'b1;          end
      OP_DIV:   begin hilo_c = {rem_s, quo_s}; we_c = (b != 32'd0); end
      OP_DIVU:  begin hilo_c = {rem_u, quo_u}; we_c = (b != 32'd0); end
`ifdef MDU_MADD_EN
      OP_MADD:  begin hilo_c = {hi, lo} + prod_s; we_c = 1'b1; end
      OP_MADDU: begin hilo_c = {hi, lo} + prod_u; we_c = 1'b1; end
      OP_MSUB:  begin hilo_c = {hi, lo} - prod_s; we_c = 1'b1; end
      OP_MSUBU: begin hilo_c = {hi, lo} - prod_u; we_c = 1'b1; end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_ex.sv
// EX-stage multiply/divide unit: busy-counter FSM, operand latches and HI/LO registers.
// MADD/MADDU/MSUB/MSUBU are accepted only when MDU_MADD_EN is defined.
module mdu_ex
  import mdu_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [OP_W-1:0] MDOp,
  input  logic [31:0]     A,
  input  logic [31:0]     B,
  output logic            busy,
  output logic [31:0]     HI,
  output logic [31:0]     LO,
  output logic [31:0]     MDM_RD
);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [OP_W-1:0]  op_q;
  logic [31:0]      a_q, b_q;
  logic             load, res_we, mt_hi, mt_lo;
  logic [63:0]      hilo_c;
  logic             we_c;

  mdu_arith u_arith (
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .hi     (HI),
    .lo     (LO),
    .hilo_c (hilo_c),
    .we_c   (we_c)
  );

  // Next-state, counter and write strobes; start is ignored outside IDLE.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    load    = 1'b0;
    res_we  = 1'b0;
    mt_hi   = 1'b0;
    mt_lo   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (is_mul_op(MDOp) || is_div_op(MDOp)) begin
            load    = 1'b1;
            state_n = BUSY;
            cnt_n   = is_div_op(MDOp) ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
          end else if (MDOp == OP_MTHI) begin
            mt_hi = 1'b1;
          end else if (MDOp == OP_MTLO) begin
            mt_lo = 1'b1;
          end
        end
      end
      BUSY: begin
        cnt_n = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          state_n = IDLE;
          res_we  = we_c;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      op_q  <= OP_NONE;
      a_q   <= '0;
      b_q   <= '0;
      HI    <= '0;
      LO    <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (load) begin
        op_q <= MDOp;
        a_q  <= A;
        b_q  <= B;
      end
      if (res_we) begin
        HI <= hilo_c[63:32];
        LO <= hilo_c[31:0];
      end else begin
        if (mt_hi) HI <= A;
        if (mt_lo) LO <= A;
      end
    end
  end

  assign busy = (state == BUSY);

  // Read port for mfhi/mflo, zero latency from MDOp and the registers.
  always_comb begin
    MDM_RD = 32'd0;
    if (MDOp == OP_MFHI)      MDM_RD = HI;
    else if (MDOp == OP_MFLO) MDM_RD = LO;
  end

endmodule
